// File: rtl/fifo_read_port.sv
// fifo_read_port
// Read-side output stage of an asynchronous FIFO. A two-entry buffer
// (head, tail) prefetches words from the FIFO memory, so the consumer
// sees a registered valid/data pair and can take one word per cycle.
//
// Handshake: a word moves to the consumer on every rising read_clk edge
// where out_valid=1 and out_ready=1. out_valid never depends on out_ready.
// out_data is held stable while out_valid=1 and out_ready=0.
// On the FIFO side, read_increment=1 means "the word on read_data is
// taken at this edge, advance the read pointer".
//
// Optional feature: define READ_PORT_LEVEL_EN to get a registered
// occupancy count on read_level. Without it, read_level is tied to 0.
//
// Ports:
//   read_clk, read_reset_n   read-domain clock, async active-low reset
//   read_empty               registered FIFO-empty flag
//   read_data                memory word at the current read address
//   read_pointer             Gray read pointer
//   read_to_write_pointer    Gray write pointer, synchronised to read_clk
//   read_increment           pop request to the pointer/empty stage
//   out_data, out_valid      head word and its valid flag
//   out_ready                consumer accepts out_data
//   read_level               occupancy in words (0 unless enabled)
//   debug_state              current buffer state (0 EMPTY, 1 ONE, 2 FULL)
module fifo_read_port #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_SIZE = 3
) (
  input  logic                    read_clk,
  input  logic                    read_reset_n,
  input  logic                    read_empty,
  input  logic [DATA_WIDTH-1:0]   read_data,
  input  logic [ADDRESS_SIZE:0]   read_pointer,
  input  logic [ADDRESS_SIZE:0]   read_to_write_pointer,
  output logic                    read_increment,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_SIZE:0]   read_level,
  output logic [1:0]              debug_state
);

  // Encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   head, head_next;
  logic [DATA_WIDTH-1:0]   tail, tail_next;
  logic                    push, pop;

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    // Only registered signals feed push, so there is no combinational
    // path from out_ready to read_increment. FULL never refills, even
    // when draining this cycle; the slot is refilled on the next cycle.
    push = read_reset_n & ~read_empty & (state != FULL);
    pop  = (state != EMPTY) & out_ready;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          head_next  = read_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next = read_data;
        end else if (push) begin
          state_next = FULL;
          tail_next  = read_data;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
          head_next  = tail;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign read_increment = push;
  assign out_valid      = (state != EMPTY);
  assign out_data       = head;
  assign debug_state    = state;

`ifdef READ_PORT_LEVEL_EN
  function automatic logic [ADDRESS_SIZE:0] gray2bin(input logic [ADDRESS_SIZE:0] g);
    logic [ADDRESS_SIZE:0] b;
    b[ADDRESS_SIZE] = g[ADDRESS_SIZE];
    for (int i = ADDRESS_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Modular subtraction handles pointer wrap; the extra MSB keeps
  // "completely full" (2^ADDRESS_SIZE) distinct from empty.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      read_level <= '0;
    end else begin
      read_level <= gray2bin(read_to_write_pointer) - gray2bin(read_pointer);
    end
  end
`else
  logic unused_pointers;
  assign unused_pointers = ^{read_pointer, read_to_write_pointer};
  assign read_level      = '0;
`endif

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port. The upstream FIFO is modelled as a queue of
// words (src_q); the output buffer is modelled as a queue of at most two
// words (buf_q); exp_q holds every word handed to the FIFO, in order, and
// is consumed as words leave on the out_valid/out_ready handshake.
module tb_fifo_read_port;
  localparam int DW = 8;
  localparam int AW = 3;

`ifdef READ_PORT_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  logic          read_clk;
  logic          read_reset_n;
  logic          read_empty;
  logic [DW-1:0] read_data;
  logic [AW:0]   read_pointer;
  logic [AW:0]   read_to_write_pointer;
  logic          read_increment;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   read_level;
  logic [1:0]    debug_state;

  fifo_read_port #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AW)) dut (
    .read_clk              (read_clk),
    .read_reset_n          (read_reset_n),
    .read_empty            (read_empty),
    .read_data             (read_data),
    .read_pointer          (read_pointer),
    .read_to_write_pointer (read_to_write_pointer),
    .read_increment        (read_increment),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .read_level            (read_level),
    .debug_state           (debug_state)
  );

  // Clock / reset
  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  // Scoreboard and model state
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] buf_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            pushes   = 0;
  int            pops     = 0;
  int            step_no  = 0;
  int            first_pop_step = -1;
  int            last_pop_step  = -1;
  int            rd_bin = 0;
  int            wr_bin = 0;
  logic [AW:0]   exp_level = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [AW:0] level_of(input int w, input int r);
    int d;
    d = (w - r) % 16;
    if (d < 0) d += 16;
    return LEVEL_EN ? d[AW:0] : '0;
  endfunction

  task automatic load(input logic [DW-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // advance the model at the rising edge.
  task automatic step(input logic rdy);
    logic          exp_push, exp_pop;
    logic [DW-1:0] seen;
    @(negedge read_clk);
    read_empty            = (src_q.size() == 0);
    read_data             = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
    out_ready             = rdy;
    read_pointer          = to_gray(rd_bin);
    read_to_write_pointer = to_gray(wr_bin);
    #1;
    exp_push = (src_q.size() != 0) && (buf_q.size() < 2);
    exp_pop  = (buf_q.size() != 0) && rdy;
    check("read_increment", 32'(read_increment), 32'(exp_push));
    check("out_valid", 32'(out_valid), 32'(buf_q.size() != 0));
    if (buf_q.size() != 0) check("out_data", 32'(out_data), 32'(buf_q[0]));
    check("state", 32'(debug_state), 32'(buf_q.size()));
    check("read_level", 32'(read_level), 32'(exp_level));
    seen = out_data;
    @(posedge read_clk);
    step_no++;
    if (exp_pop) begin
      void'(buf_q.pop_front());
      if (exp_q.size() != 0) check("order", 32'(seen), 32'(exp_q.pop_front()));
      else check("extra_word", 32'(seen), 32'hFFFF_FFFF);
      pops++;
      if (first_pop_step < 0) first_pop_step = step_no;
      last_pop_step = step_no;
    end
    if (exp_push) begin
      buf_q.push_back(src_q.pop_front());
      pushes++;
    end
    exp_level = level_of(wr_bin, rd_bin);
  endtask

  task automatic clear_counts();
    pushes = 0; pops = 0; first_pop_step = -1; last_pop_step = -1;
  endtask

  initial begin
    // Reset with the FIFO reporting non-empty.
    read_reset_n = 1'b0;
    read_empty   = 1'b0;
    read_data    = 8'h5A;
    out_ready    = 1'b1;
    read_to_write_pointer = to_gray(5);
    read_pointer = to_gray(0);
    repeat (2) @(posedge read_clk);
    #1;
    check("rst_read_increment", 32'(read_increment), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_read_level", 32'(read_level), 32'd0);
    check("rst_state", 32'(debug_state), 32'd0);
    @(negedge read_clk);
    read_empty = 1'b1;
    read_pointer = to_gray(0);
    read_to_write_pointer = to_gray(0);
    read_reset_n = 1'b1;
    exp_level = level_of(0, 0);

    // Single word with the consumer stalled.
    clear_counts();
    load(8'hA5);
    repeat (3) step(1'b0);
    check("single_pushes", 32'(pushes), 32'd1);
    check("single_out_data", 32'(out_data), 32'hA5);
    repeat (2) step(1'b1);
    check("single_pops", 32'(pops), 32'd1);

    // Backpressure: four words, only two may enter the buffer.
    clear_counts();
    for (int i = 1; i <= 4; i++) load(DW'(i));
    repeat (4) step(1'b0);
    check("bp_pushes", 32'(pushes), 32'd2);
    check("bp_state_full", 32'(debug_state), 32'd2);
    repeat (7) step(1'b1);
    check("bp_pops", 32'(pops), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Streaming: eight words at one per cycle after the fill cycle.
    clear_counts();
    for (int i = 0; i < 8; i++) load(DW'(8'h10 + i));
    repeat (11) step(1'b1);
    check("stream_pops", 32'(pops), 32'd8);
    check("stream_span", 32'(last_pop_step - first_pop_step), 32'd7);

    // Level reporting, including pointer wrap-around.
    wr_bin = 8; rd_bin = 1;
    repeat (2) step(1'b1);
    check("level_7", 32'(read_level), LEVEL_EN ? 32'd7 : 32'd0);
    wr_bin = 1; rd_bin = 9;
    repeat (2) step(1'b1);
    check("level_wrap_8", 32'(read_level), LEVEL_EN ? 32'd8 : 32'd0);
    wr_bin = 0; rd_bin = 0;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && src_q.size() < 8) load(DW'($urandom));
      rd_bin = $urandom_range(0, 15);
      wr_bin = rd_bin + $urandom_range(0, 8);
      step(1'($urandom_range(0, 1)));
    end
    rd_bin = 0; wr_bin = 0;
    repeat (14) step(1'b1);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset while FULL: buffered words vanish without a clock edge.
    for (int i = 0; i < 4; i++) load(DW'(8'hC0 + i));
    repeat (3) step(1'b0);
    check("mid_full", 32'(debug_state), 32'd2);
    #3;
    read_reset_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_data", 32'(out_data), 32'd0);
    check("mid_read_increment", 32'(read_increment), 32'd0);
    check("mid_state", 32'(debug_state), 32'd0);
    check("mid_read_level", 32'(read_level), 32'd0);
    src_q.delete(); buf_q.delete(); exp_q.delete();
    @(negedge read_clk);
    read_empty   = 1'b1;
    read_reset_n = 1'b1;
    exp_level = level_of(wr_bin, rd_bin);
    clear_counts();
    repeat (3) step(1'b1);
    check("post_rst_pushes", 32'(pushes), 32'd0);
    check("post_rst_state", 32'(debug_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_read_port.md
FIFO_READ_PORT -- requirements
Module: fifo_read_port

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO data word.
REQ-002 Parameter ADDRESS_SIZE, default 3, FIFO address bits; the FIFO depth is 2^ADDRESS_SIZE.
REQ-003 read_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 read_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 read_empty  input  1  registered FIFO-empty flag from the read pointer/empty stage.
REQ-006 read_data  input  DATA_WIDTH  FIFO memory word at the current read address, combinational read.
REQ-007 read_pointer  input  ADDRESS_SIZE+1  Gray-coded read pointer from the read pointer/empty stage.
REQ-008 read_to_write_pointer  input  ADDRESS_SIZE+1  Gray-coded write pointer, already synchronised into read_clk.
REQ-009 read_increment  output  1  pop request to the read pointer/empty stage.
REQ-010 out_data  output  DATA_WIDTH  head word presented to the consumer.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 read_level  output  ADDRESS_SIZE+1  FIFO occupancy in words, as seen from the read domain.

Function
REQ-014 The block SHALL implement a 2-entry output buffer (head, tail) with state EMPTY (0 words), ONE (1 word), or FULL (2 words).
REQ-015 read_increment SHALL equal ~read_empty AND (state != FULL) AND read_reset_n.
- This is combinational from registered signals only.
REQ-016 A push SHALL be defined as read_increment=1; at that clock edge the block captures read_data, which is the word addressed before the pointer advances.
REQ-017 A pop SHALL be defined as out_valid=1 AND out_ready=1 at a clock edge.
REQ-018 State transitions SHALL follow the rule next count = count + push - pop:
- EMPTY->ONE on a push.
- ONE->FULL on a push without a pop.
- ONE->EMPTY on a pop without a push.
- ONE->ONE on a simultaneous push and pop.
- FULL->ONE on a pop.
REQ-019 On a push into EMPTY, or a simultaneous push and pop in ONE, the captured word SHALL go to head.
- On a push in ONE without a pop, the captured word SHALL go to tail.
REQ-020 On a pop in FULL, tail SHALL move to head; words SHALL leave in the order they were pushed.
REQ-021 out_valid SHALL equal (state != EMPTY), and out_data SHALL equal head.
- While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-022 Latency: read_empty falling before edge N gives read_increment=1 during cycle N.
- out_valid SHALL rise after edge N+1, with out_data equal to the first word.
REQ-023 Throughput: with out_ready held at 1 and the FIFO non-empty, the block SHALL sustain one word per read_clk cycle.
REQ-024 The block SHALL NOT push in FULL, even when a pop occurs in the same cycle.
- The next pop slot is refilled on the following cycle.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-026 While read_reset_n=0, the block SHALL force:
- state=EMPTY, out_valid=0, out_data=0, read_level=0;
- read_increment=0 regardless of read_empty.
REQ-027 Reset asserted mid-operation SHALL discard buffered words immediately (asynchronously).
- The first push after deassertion SHALL occur no earlier than the first rising edge at which read_empty=0.

Configuration
REQ-028 With macro READ_PORT_LEVEL_EN defined, read_level SHALL be a register updated every cycle to (gray2bin(read_to_write_pointer) - gray2bin(read_pointer)) modulo 2^(ADDRESS_SIZE+1).
- Range is 0..2^ADDRESS_SIZE, including pointer wrap-around.
REQ-029 Without READ_PORT_LEVEL_EN, read_level SHALL be constant 0 and no Gray-to-binary logic SHALL be synthesised.

Verification
REQ-030 Reset: read_reset_n=0 with read_empty=0 -> read_increment=0, out_valid=0, read_level=0.
REQ-031 Single word: read_empty falls, read_data=8'hA5, out_ready=0:
- read_increment pulses for 1 cycle;
- out_valid=1 with out_data=8'hA5 one cycle later;
- state=ONE.
REQ-032 Backpressure: 4 words 8'h01..8'h04 in the FIFO, out_ready=0:
- exactly 2 pushes occur, then read_increment=0 (FULL);
- raising out_ready drains 01,02,03,04 in order;
- no word is lost or duplicated.
REQ-033 Streaming: 8 words 8'h10..8'h17 with out_ready=1 -> after the 1-cycle fill, one word per cycle, in order.
REQ-034 Level (macro defined): write pointer Gray 4'b1100 (bin 8), read pointer Gray 4'b0001 (bin 1) -> read_level=7 one cycle later.
- Write pointer bin 1 with read pointer bin 9 -> read_level=8 (wrap-around).
REQ-035 Reset mid-operation: reset pulsed while FULL -> out_valid drops asynchronously.
- After release with read_empty=1, state remains EMPTY.
